// File: rtl/bus_requester.sv
// bus_requester: client side of the two-way req/gnt arbiter. It takes a job of
// `len` beats, raises req and counts one beat per granted XFER cycle. If the
// grant drops mid-burst, it re-arbitrates and resumes. Every job ends with a
// one-cycle RELEASE gap with req low. req/busy are decoded from registered
// state only, because the arbiter drives gnt combinationally from req.
module bus_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Wait-counter value on the last tolerated ungranted REQ cycle.
  // It is unused when TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [TO_W-1:0]  r_wait;
  logic             r_done;
  logic             r_timeout;

  logic w_accept;
  logic w_len_zero;
  logic w_timeout_hit;
  logic w_last_beat;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_len_zero    = (len == '0);
  assign w_timeout_hit = (TIMEOUT != 0) && (r_state == S_REQ) && !gnt && (r_wait == TO_LAST);
  assign w_last_beat   = (r_state == S_XFER) && gnt && (r_remaining == LEN_W'(1));

  // State register; active-low synchronous reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_len_zero ? S_RELEASE : S_REQ;
      end
      S_REQ: begin
        if (gnt)                w_next = S_XFER;
        else if (w_timeout_hit) w_next = S_RELEASE;
      end
      S_XFER: begin
        if (!gnt)             w_next = S_REQ;
        else if (w_last_beat) w_next = S_RELEASE;
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Job bookkeeping: beat counters, wait counter and the registered done/timeout pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_wait      <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_remaining <= len;
            r_beat_cnt  <= '0;
            r_wait      <= '0;
            r_done      <= w_len_zero;
          end
        end
        S_REQ: begin
          if (!gnt) begin
            if (w_timeout_hit) begin
              r_timeout   <= 1'b1;
              r_remaining <= '0;
            end else begin
              r_wait <= r_wait + TO_W'(1);
            end
          end
        end
        S_XFER: begin
          if (gnt) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_beat_cnt  <= r_beat_cnt + LEN_W'(1);
            r_done      <= w_last_beat;
          end else begin
            // Grant lost mid-burst: re-arbitrate with a fresh timeout window.
            r_wait <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: req/busy from state only; beat_valid also qualifies on gnt.
  always_comb begin
    req        = (r_state == S_REQ) || (r_state == S_XFER);
    busy       = (r_state != S_IDLE);
    beat_valid = (r_state == S_XFER) && gnt;
  end

  assign beat_cnt    = r_beat_cnt;
  assign done        = r_done;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_bus_requester.sv
// Bench for bus_requester: one instance on a bench-controlled grant (ideal or
// scripted), plus two instances sharing a fixed-priority two-way arbiter.
// Each step pushes the expected output vector into a queue; the negedge monitor
// pops the entries and compares them.
module tb_bus_requester;

  logic       clk = 1'b0;
  logic       rst, start, ideal, gnt_drv;
  logic [3:0] len;
  logic       m_gnt, m_req, m_busy, m_bv, m_done, m_terr;
  logic [3:0] m_cnt;

  logic       p_start;
  logic [3:0] p_len;
  logic       a_gnt, a_req, a_busy, a_bv, a_done, a_terr;
  logic [3:0] a_cnt;
  logic       b_gnt, b_req, b_busy, b_bv, b_done, b_terr;
  logic [3:0] b_cnt;

  typedef struct {
    int         sel;
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign m_gnt = ideal ? m_req : gnt_drv;
  assign a_gnt = a_req;
  assign b_gnt = b_req & ~a_req;

  bus_requester #(.LEN_W(4), .TIMEOUT(5), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .gnt(m_gnt),
    .req(m_req), .busy(m_busy), .beat_valid(m_bv), .beat_cnt(m_cnt),
    .done(m_done), .timeout_err(m_terr)
  );

  bus_requester #(.LEN_W(4), .TIMEOUT(15), .TO_W(5)) u_req0 (
    .clk(clk), .rst(rst), .start(p_start), .len(p_len), .gnt(a_gnt),
    .req(a_req), .busy(a_busy), .beat_valid(a_bv), .beat_cnt(a_cnt),
    .done(a_done), .timeout_err(a_terr)
  );

  bus_requester #(.LEN_W(4), .TIMEOUT(15), .TO_W(5)) u_req1 (
    .clk(clk), .rst(rst), .start(p_start), .len(p_len), .gnt(b_gnt),
    .req(b_req), .busy(b_busy), .beat_valid(b_bv), .beat_cnt(b_cnt),
    .done(b_done), .timeout_err(b_terr)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input string tag, input logic r, input logic b,
                     input logic bv, input logic d, input logic t, input logic [3:0] c);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.v   = {r, b, bv, d, t, c};
    sb.push_back(e);
  endtask

  task automatic m(input string tag, input logic r, input logic b, input logic bv,
                   input logic d, input logic t, input logic [3:0] c);
    chk(0, tag, r, b, bv, d, t, c);
  endtask

  // Monitor: compare every expectation queued for this cycle away from the rising edge.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [8:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = {m_req, m_busy, m_bv, m_done, m_terr, m_cnt};
        1:       obs = {a_req, a_busy, a_bv, a_done, a_terr, a_cnt};
        default: obs = {b_req, b_busy, b_bv, b_done, b_terr, b_cnt};
      endcase
      checks++;
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s: observed {req,busy,bv,done,terr,cnt}=%b expected %b", e.tag, obs, e.v);
      end
    end
  end

  // Watchdog: the directed sequence is short, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    logic g2[8];
    logic bv2[8];
    int   cnt2[8];
    g2   = '{1, 1, 1, 0, 0, 1, 1, 1};
    bv2  = '{0, 1, 1, 0, 0, 0, 1, 1};
    cnt2 = '{0, 0, 1, 2, 2, 2, 2, 3};

    rst = 1'b0; start = 1'b0; len = '0; ideal = 1'b1; gnt_drv = 1'b0;
    p_start = 1'b0; p_len = '0;
    next();
    next();
    m("rst_m", 0, 0, 0, 0, 0, 0);
    chk(1, "rst_a", 0, 0, 0, 0, 0, 0);
    chk(2, "rst_b", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Test 1: ideal arbiter, len=3.
    next(); start = 1'b1; len = 4'd3; m("t1_start", 0, 0, 0, 0, 0, 0);
    next(); start = 1'b0; m("t1_req", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      next(); m("t1_beat", 1, 1, 1, 0, 0, 4'(i));
    end
    next(); m("t1_done", 0, 1, 0, 1, 0, 3);
    checks++;
    if (m_done !== 1'b1) begin
      failures++;
      $error("FAIL t1_done_direct: observed done=%b expected 1", m_done);
    end
    checks++;
    if (m_req !== 1'b0) begin
      failures++;
      $error("FAIL t1_req_low_direct: observed req=%b expected 0", m_req);
    end
    checks++;
    if (m_busy !== 1'b1) begin
      failures++;
      $error("FAIL t1_busy_direct: observed busy=%b expected 1", m_busy);
    end
    checks++;
    if (m_cnt !== 4'd3) begin
      failures++;
      $error("FAIL t1_cnt_direct: observed beat_cnt=%0d expected 3", m_cnt);
    end
    next(); m("t1_idle", 0, 0, 0, 0, 0, 3);

    // Test 2: scripted grant with a two-cycle withdrawal mid-burst.
    ideal = 1'b0;
    next(); start = 1'b1; len = 4'd4; gnt_drv = 1'b0; m("t2_start", 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 8; i++) begin
      next(); start = 1'b0; gnt_drv = g2[i];
      m("t2_burst", 1, 1, bv2[i], 0, 0, 4'(cnt2[i]));
    end
    next(); gnt_drv = 1'b0; m("t2_done", 0, 1, 0, 1, 0, 4);
    next(); m("t2_idle", 0, 0, 0, 0, 0, 4);

    // Test 3: grant never given; timeout after 5 ungranted REQ cycles.
    next(); start = 1'b1; len = 4'd7; m("t3_start", 0, 0, 0, 0, 0, 4);
    for (int i = 0; i < 5; i++) begin
      next(); start = 1'b0; m("t3_wait", 1, 1, 0, 0, 0, 0);
    end
    next(); m("t3_timeout", 0, 1, 0, 0, 1, 0);
    next(); m("t3_idle", 0, 0, 0, 0, 0, 0);

    // Test 3b: timeout after a partial burst; the wait count restarts and beat_cnt holds.
    next(); start = 1'b1; len = 4'd4; m("t3b_start", 0, 0, 0, 0, 0, 0);
    next(); start = 1'b0; m("t3b_wait", 1, 1, 0, 0, 0, 0);
    next(); m("t3b_wait", 1, 1, 0, 0, 0, 0);
    next(); gnt_drv = 1'b1; m("t3b_grant", 1, 1, 0, 0, 0, 0);
    next(); m("t3b_beat", 1, 1, 1, 0, 0, 0);
    next(); gnt_drv = 1'b0; m("t3b_drop", 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      next();
      if (i == 1) begin start = 1'b1; len = 4'd1; end
      else        start = 1'b0;
      m("t3b_rewait", 1, 1, 0, 0, 0, 1);
    end
    next(); m("t3b_timeout", 0, 1, 0, 0, 1, 1);
    next(); m("t3b_idle", 0, 0, 0, 0, 0, 1);

    // Test 4: zero-length job.
    next(); start = 1'b1; len = 4'd0; m("t4_start", 0, 0, 0, 0, 0, 1);
    next(); start = 1'b0; m("t4_done", 0, 1, 0, 1, 0, 0);
    next(); m("t4_idle", 0, 0, 0, 0, 0, 0);

    // Test 5: two requesters on a fixed-priority arbiter, both len=2.
    next(); p_start = 1'b1; p_len = 4'd2;
    chk(1, "t5a_start", 0, 0, 0, 0, 0, 0); chk(2, "t5b_start", 0, 0, 0, 0, 0, 0);
    next(); p_start = 1'b0;
    chk(1, "t5a_req", 1, 1, 0, 0, 0, 0); chk(2, "t5b_wait", 1, 1, 0, 0, 0, 0);
    next(); chk(1, "t5a_beat1", 1, 1, 1, 0, 0, 0); chk(2, "t5b_wait", 1, 1, 0, 0, 0, 0);
    next(); chk(1, "t5a_beat2", 1, 1, 1, 0, 0, 1); chk(2, "t5b_wait", 1, 1, 0, 0, 0, 0);
    next(); chk(1, "t5a_done", 0, 1, 0, 1, 0, 2); chk(2, "t5b_grant", 1, 1, 0, 0, 0, 0);
    next(); chk(1, "t5a_idle", 0, 0, 0, 0, 0, 2); chk(2, "t5b_beat1", 1, 1, 1, 0, 0, 0);
    next(); chk(1, "t5a_idle", 0, 0, 0, 0, 0, 2); chk(2, "t5b_beat2", 1, 1, 1, 0, 0, 1);
    next(); chk(2, "t5b_done", 0, 1, 0, 1, 0, 2);
    next(); chk(2, "t5b_idle", 0, 0, 0, 0, 0, 2);

    // Test 6: reset during XFER after one beat, then a clean 4-beat job.
    ideal = 1'b1;
    next(); start = 1'b1; len = 4'd4; m("t6_start", 0, 0, 0, 0, 0, 0);
    next(); start = 1'b0; m("t6_req", 1, 1, 0, 0, 0, 0);
    next(); m("t6_beat1", 1, 1, 1, 0, 0, 0);
    next(); rst = 1'b0; m("t6_beat2", 1, 1, 1, 0, 0, 1);
    next(); rst = 1'b1; m("t6_reset", 0, 0, 0, 0, 0, 0);
    next(); start = 1'b1; len = 4'd4; m("t6_restart", 0, 0, 0, 0, 0, 0);
    next(); start = 1'b0; m("t6_req2", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next(); m("t6_beat", 1, 1, 1, 0, 0, 4'(i));
    end
    next(); m("t6_done", 0, 1, 0, 1, 0, 4);
    next(); m("t6_idle", 0, 0, 0, 0, 0, 4);
    checks++;
    if (m_busy !== 1'b0) begin
      failures++;
      $error("FAIL t6_busy_direct: observed busy=%b expected 0", m_busy);
    end
    checks++;
    if (m_req !== 1'b0) begin
      failures++;
      $error("FAIL t6_req_direct: observed req=%b expected 0", m_req);
    end
    checks++;
    if (m_done !== 1'b0) begin
      failures++;
      $error("FAIL t6_done_direct: observed done=%b expected 0", m_done);
    end
    checks++;
    if (m_cnt !== 4'd4) begin
      failures++;
      $error("FAIL t6_cnt_direct: observed beat_cnt=%0d expected 4", m_cnt);
    end

    next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
